fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_byte_assembler.sv | 40 ++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [63:0] RESET_PC    = 64'h0;

    // One-hot write enable for the byte lane addressed by idx.
    function automatic logic [3:0] lane_decode(input logic [1:0] idx);
        lane_decode = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Holds the four instruction byte lanes; bytes land little-endian by lane index.
module fetch_byte_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    output logic [31:0] word
);

    logic [3:0]      lane_we_s;
    logic [3:0][7:0] lanes_r;

    // Decode the target lane of an accepted byte.
    always_comb begin
        if (capture) begin
            lane_we_s = lane_decode(lane);
        end else begin
            lane_we_s = 4'b0000;
        end
    end

    // Byte lane storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_r <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we_s[i]) begin
                    lanes_r[i] <= byte_in;
                end
            end
        end
    end

    assign word = lanes_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches one instruction a byte at a time and holds it until the consumer takes it.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    INSTR_BYTES = fetch_pkg::INSTR_BYTES,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(fetch_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] instr_pc
);

    localparam logic [1:0] LAST_IDX = 2'(INSTR_BYTES - 1);

    fetch_state_e          state_r, next_state_s;
    logic [DATA_WIDTH-1:0] pc_r, next_pc_s;
    logic [1:0]            byte_idx_r, next_idx_s;
    logic                  capture_s;
    logic                  mem_req_r, instr_valid_r;
    logic [DATA_WIDTH-1:0] mem_addr_r;

    // Next-state and datapath decode; a redirect overrides everything, including a same-cycle ack.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        next_idx_s   = byte_idx_r;
        capture_s    = 1'b0;
        if (redirect_valid) begin
            next_pc_s  = redirect_pc;
            next_idx_s = 2'd0;
            if (fetch_en) begin
                next_state_s = ST_FETCH;
            end else begin
                next_state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch_en) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (mem_req_r && mem_ack) begin
                        capture_s  = 1'b1;
                        next_idx_s = byte_idx_r + 2'd1;
                        if (byte_idx_r == LAST_IDX) begin
                            next_state_s = ST_HOLD;
                        end else begin
                            next_state_s = ST_FETCH;
                        end
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        next_pc_s  = pc_r + DATA_WIDTH'(INSTR_BYTES);
                        next_idx_s = 2'd0;
                        if (fetch_en) begin
                            next_state_s = ST_FETCH;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end else begin
                        next_state_s = ST_HOLD;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_idx_s   = 2'd0;
                end
            endcase
        end
    end

    // State, PC and registered memory/consumer outputs, all derived from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            byte_idx_r    <= 2'd0;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= RESET_PC;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= next_pc_s;
            byte_idx_r    <= next_idx_s;
            mem_req_r     <= (next_state_s == ST_FETCH);
            mem_addr_r    <= next_pc_s + DATA_WIDTH'(next_idx_s);
            instr_valid_r <= (next_state_s == ST_HOLD);
        end
    end

    fetch_byte_assembler u_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture_s),
        .lane    (byte_idx_r),
        .byte_in (mem_rdata),
        .word    (instr)
    );

    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr_pc    = pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against an instruction-stream scoreboard.
module tb_fetch_sequencer;

    localparam int DW = 64;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          fetch_en       = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [DW-1:0] redirect_pc    = '0;
    logic          instr_ready    = 1'b0;
    logic          mem_req, mem_ack, instr_valid;
    logic [DW-1:0] mem_addr, instr_pc;
    logic [7:0]    mem_rdata;
    logic [31:0]   instr;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            wait_cfg = 0;
    int            wait_cnt = 0;
    logic          stray_ack = 1'b0;
    logic [7:0]    mem_key   = 8'h00;

    logic [DW-1:0] exp_pc = '0;
    int            nb       = 0;
    int            accepts  = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Memory: content is a fixed function of the address; ack after wait_cfg stall cycles.
    assign mem_rdata = mem_addr[7:0] ^ mem_key;
    assign mem_ack   = (mem_req && (wait_cnt >= wait_cfg)) || stray_ack;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [DW-1:0] pc);
        logic [31:0] w;
        logic [DW-1:0] a;
        for (int b = 0; b < 4; b++) begin
            a = pc + DW'(b);
            w[8*b +: 8] = a[7:0] ^ mem_key;
        end
        return w;
    endfunction

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!instr_valid && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) check_eq("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_ready();
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    // Scoreboard: expected PC and bytes fetched so far, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc = '0;
                nb     = 0;
            end else begin
                check_eq("valid_vs_bytes", 64'(instr_valid), 64'(nb == 4));
                if (instr_valid) begin
                    check_eq("hold_instr", 64'(instr), 64'(exp_instr(exp_pc)));
                    check_eq("hold_pc", instr_pc, exp_pc);
                    check_eq("hold_no_req", 64'(mem_req), 64'd0);
                end
                if (mem_req) check_eq("fetch_addr", mem_addr, exp_pc + DW'(nb));
                if (redirect_valid) begin
                    exp_pc = redirect_pc;
                    nb     = 0;
                end else begin
                    if (mem_req && mem_ack) nb++;
                    if (instr_valid && instr_ready) begin
                        exp_pc = exp_pc + DW'(4);
                        nb     = 0;
                        accepts++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] wrap_seq [4];
        wrap_seq[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        wrap_seq[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        wrap_seq[2] = 64'h0;
        wrap_seq[3] = 64'h1;

        #12;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_addr", mem_addr, 64'd0);
        check_eq("rst_pc", instr_pc, 64'd0);
        check_eq("rst_instr", 64'(instr), 64'd0);

        // First instruction with zero-wait memory.
        @(posedge clk); #1;
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        wait_valid(20, n);
        check_eq("first_latency", 64'(n), 64'd5);
        check_eq("first_instr", 64'(instr), 64'h0302_0100);
        check_eq("first_pc", instr_pc, 64'd0);

        // Back-pressure, then accept and fetch the next word.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall_instr", 64'(instr), 64'h0302_0100);
            check_eq("stall_pc", instr_pc, 64'd0);
            check_eq("stall_req", 64'(mem_req), 64'd0);
        end
        pulse_ready();
        check_eq("next_req", 64'(mem_req), 64'd1);
        check_eq("next_addr", mem_addr, 64'd4);
        wait_valid(20, n);
        check_eq("second_instr", 64'(instr), 64'h0706_0504);
        check_eq("second_pc", instr_pc, 64'd4);

        // Redirect at byte 2 with a coincident ack.
        pulse_ready();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_redirect_addr", mem_addr, 64'd10);
        check_eq("pre_redirect_ack", 64'(mem_ack), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        check_eq("redirect_addr", mem_addr, 64'h20);
        check_eq("redirect_valid_clr", 64'(instr_valid), 64'd0);
        wait_valid(20, n);
        check_eq("redirect_instr", 64'(instr), 64'h2322_2120);
        check_eq("redirect_pc", instr_pc, 64'h20);

        // Unaligned redirect across the address wrap, with a coincident ready.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        instr_ready    = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("wrap_addr", mem_addr, wrap_seq[i]);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        wait_valid(20, n);
        check_eq("wrap_instr", 64'(instr), 64'h0100_FFFE);
        check_eq("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFE);

        // Three wait states per byte.
        wait_cfg = 3;
        pulse_ready();
        wait_valid(40, n);
        check_eq("slow_latency", 64'(n), 64'd16);
        check_eq("slow_instr", 64'(instr), 64'h0504_0302);
        check_eq("slow_pc", instr_pc, 64'd2);

        // Asynchronous reset in the middle of a fetch.
        wait_cfg = 0;
        pulse_ready();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", 64'(mem_req), 64'd0);
        check_eq("arst_valid", 64'(instr_valid), 64'd0);
        check_eq("arst_addr", mem_addr, 64'd0);
        check_eq("arst_pc", instr_pc, 64'd0);
        check_eq("arst_instr", 64'(instr), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wait_valid(20, n);
        check_eq("arst_latency", 64'(n), 64'd5);
        check_eq("arst_refetch_instr", 64'(instr), 64'h0302_0100);
        check_eq("arst_refetch_pc", instr_pc, 64'd0);

        // Randomized traffic against the scoreboard.
        rst_n   = 1'b0;
        mem_key = 8'($urandom);
        @(posedge clk); @(posedge clk); #1;
        rst_n   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            fetch_en       = ($urandom_range(0, 9) != 0);
            instr_ready    = $urandom_range(0, 1);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
            else                           redirect_pc = {$urandom, $urandom};
            wait_cfg       = $urandom_range(0, 3);
            stray_ack      = !mem_req && ($urandom_range(0, 3) == 0);
        end
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        stray_ack      = 1'b0;
        instr_ready    = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rand_accepts", 64'(accepts > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
